multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencing controller for the MIPS-subset CPU datapath (addu, subu, ori, lw, sw, beq, lui, jal, jr).
- Replaces single-cycle decoding with an FSM that drives IR/PC/GRF/DM enables per phase: FETCH, DECODE, EXEC, MEM, WB.
- Handshakes with a variable-latency data memory.
- Sits between the IR (op/funct), the ALU zero flag, and the datapath muxes/enables.

Parameters:
WAIT_MAX, 15, max cycles spent in MEM awaiting mem_ready before timeout abort (1..255)
CNT_W, 8, width of internal wait counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  6  IR[31:26], stable from DECODE onward
funct  input  6  IR[5:0]
zero  input  1  ALU equal flag (beq compare)
mem_ready  input  1  data memory completion, sampled in MEM
state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
IRWrite  output  1  latch instruction into IR
PCWrite  output  1  update PC this edge
PC_sel  output  4  0000 PC+4, 0001 branch target, 0010 jal target, 0011 GRF[rs]
ALUcontrol  output  4  0001 addu, 0010 subu, 0011 ori, 0100 add (lw/sw address), 0101 beq compare, 0110 lui, 0000 idle
ALUsrc  output  1  0 rt, 1 extended immediate
RegDst  output  3  000 rt, 001 rd, 010 $ra (31)
GRF_WD_sel  output  3  000 ALU result, 001 memory data, 010 PC+4
RegWrite  output  1  GRF write enable
MemRead  output  1  DM read request
MemWrite  output  1  DM write request
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal  output  1  one-cycle pulse: unrecognised op/funct, seen in DECODE
mem_timeout  output  1  sticky flag; set on MEM timeout, cleared only by reset

Behaviour:
- Reset (async): state=FETCH, wait counter=0, mem_timeout=0. While reset is high, all enables/pulses are 0 regardless of state. First FETCH occurs on the first rising edge after deassertion.
- Outputs are combinational from state, op, funct, zero, mem_ready, and the wait counter (Mealy only where stated below).
- FETCH: IRWrite=1. Next state is DECODE.
- DECODE: ALUcontrol/ALUsrc/RegDst are driven for the decoded instruction so operands settle.
  - Illegal instruction: illegal=1, PCWrite=1, PC_sel=0000, instr_done=1; next state FETCH.
  - Otherwise: next state EXEC.
- EXEC by instruction:
  - addu/subu/ori/lui: ALU op driven; next state WB.
  - lw/sw: ALUcontrol=0100, ALUsrc=1; next state MEM.
  - beq: ALUcontrol=0101. PCWrite=1, PC_sel=0001 if zero=1 else 0000. instr_done=1; next state FETCH.
  - jal: RegWrite=1, RegDst=010, GRF_WD_sel=010, PCWrite=1, PC_sel=0010, instr_done=1; next state FETCH.
  - jr: PCWrite=1, PC_sel=0011, instr_done=1; next state FETCH.
- MEM: MemRead=1 (lw) or MemWrite=1 (sw), held stable until completion. Counter increments each cycle mem_ready=0.
  - mem_ready=1, lw: next state WB.
  - mem_ready=1, sw: PCWrite=1, PC_sel=0000, instr_done=1; next state FETCH.
  - Timeout (counter==WAIT_MAX and mem_ready=0): set mem_timeout. PCWrite=1, PC_sel=0000, instr_done=1. No GRF write. Next state FETCH.
  - mem_ready=1 on the same cycle the counter hits WAIT_MAX counts as success, not timeout.
  - Counter clears on MEM exit.
- WB:
  - RegWrite=1, PCWrite=1, PC_sel=0000, instr_done=1; next state FETCH.
  - RegDst: 001 for addu/subu, 000 otherwise.
  - GRF_WD_sel: 001 for lw, 000 otherwise.
- Latency in cycles: beq/jal/jr/illegal-path = 3 (illegal = 2); ALU ops = 4; sw = 4+waits; lw = 5+waits.
- mem_ready outside MEM is ignored.
- Exactly one PCWrite and one instr_done per instruction.
- Reset mid-MEM aborts the access immediately: MemWrite drops asynchronously.
- Unused encodings of state (5–7) return to FETCH on the next edge with all enables 0.

Test Plan:
- Reset then addu (op=0, funct=100001) -> states 0,1,2,4; in WB: RegWrite=1, RegDst=001, ALUcontrol=0001; instr_done once; 4 cycles.
- lw with mem_ready high after 3 wait cycles -> states 0,1,2,3,3,3,3,4; MemRead=1 through all MEM cycles; in WB: GRF_WD_sel=001, RegWrite=1; 8 cycles total.
- beq with zero=1, then beq with zero=0 -> EXEC: PCWrite=1 with PC_sel 0001, then 0000; RegWrite=0 in both.
- jal then jr -> jal EXEC: RegDst=010, GRF_WD_sel=010, RegWrite=1, PC_sel=0010; jr EXEC: PC_sel=0011, RegWrite=0.
- sw with mem_ready held 0, WAIT_MAX=15 -> 16 MEM cycles, then mem_timeout=1 (sticky), PC_sel=0000 advance, MemWrite drops; next instruction still executes.
- Illegal op=111111 -> illegal pulse in DECODE, PC advances; async reset asserted mid-MEM of sw -> MemWrite=0 and state=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the MIPS-subset datapath (addu, subu, ori, lw, sw, beq, lui, jal, jr).
// Latency: illegal 2, beq/jal/jr 3, ALU ops 4, sw 4+waits, lw 5+waits cycles; outputs combinational from state/inputs.
// Backpressure: stalls in MEM until mem_ready, aborting after WAIT_MAX waits with a sticky mem_timeout.
// Ports: clk/reset (async, active-high); op/funct from IR; zero from ALU; mem_ready from DM;
//        state, IR/PC/GRF/DM enables, datapath mux selects, instr_done/illegal pulses, mem_timeout flag.
module multicycle_controller #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [3:0] PC_sel,
    output logic [3:0] ALUcontrol,
    output logic       ALUsrc,
    output logic [2:0] RegDst,
    output logic [2:0] GRF_WD_sel,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mem_timeout;

    // Instruction decode
    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_jal;
    logic w_aluop, w_legal;
    assign w_rtype = (op == 6'b000000);
    assign w_addu  = w_rtype && (funct == 6'b100001);
    assign w_subu  = w_rtype && (funct == 6'b100011);
    assign w_jr    = w_rtype && (funct == 6'b001000);
    assign w_ori   = (op == 6'b001101);
    assign w_lui   = (op == 6'b001111);
    assign w_lw    = (op == 6'b100011);
    assign w_sw    = (op == 6'b101011);
    assign w_beq   = (op == 6'b000100);
    assign w_jal   = (op == 6'b000011);
    assign w_aluop = w_addu || w_subu || w_ori || w_lui;
    assign w_legal = w_aluop || w_lw || w_sw || w_beq || w_jal || w_jr;

    // Operand-path controls for the decoded instruction, held from DECODE onward
    logic [3:0] w_dec_aluc;
    logic       w_dec_alus;
    logic [2:0] w_dec_rdst;
    always_comb begin
        w_dec_aluc = 4'b0000;
        w_dec_alus = 1'b0;
        w_dec_rdst = 3'b000;
        if (w_addu) begin
            w_dec_aluc = 4'b0001;
            w_dec_rdst = 3'b001;
        end else if (w_subu) begin
            w_dec_aluc = 4'b0010;
            w_dec_rdst = 3'b001;
        end else if (w_ori) begin
            w_dec_aluc = 4'b0011;
            w_dec_alus = 1'b1;
        end else if (w_lui) begin
            w_dec_aluc = 4'b0110;
            w_dec_alus = 1'b1;
        end else if (w_lw || w_sw) begin
            w_dec_aluc = 4'b0100;
            w_dec_alus = 1'b1;
        end else if (w_beq) begin
            w_dec_aluc = 4'b0101;
        end else if (w_jal) begin
            w_dec_rdst = 3'b010;
        end
    end

    // Ready in the same cycle the counter reaches WAIT_MAX is a success
    logic w_timeout;
    assign w_timeout = (r_state == S_MEM) && !mem_ready
                       && (r_wait_cnt == CNT_W'(WAIT_MAX));

    logic [2:0] w_next;
    logic       w_irw, w_pcw, w_rw, w_mr, w_mw, w_done, w_ill, w_alus;
    logic [3:0] w_pcs, w_aluc;
    logic [2:0] w_rdst, w_wdsel;

    always_comb begin
        w_next  = S_FETCH;
        w_irw   = 1'b0;
        w_pcw   = 1'b0;
        w_rw    = 1'b0;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_done  = 1'b0;
        w_ill   = 1'b0;
        w_pcs   = 4'b0000;
        w_aluc  = 4'b0000;
        w_alus  = 1'b0;
        w_rdst  = 3'b000;
        w_wdsel = 3'b000;
        if (r_state != S_FETCH && r_state <= S_WB) begin
            w_aluc = w_dec_aluc;
            w_alus = w_dec_alus;
            w_rdst = w_dec_rdst;
        end
        case (r_state)
            S_FETCH: begin
                w_irw  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_ill  = 1'b1;
                    w_pcw  = 1'b1;
                    w_done = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_aluop) begin
                    w_next = S_WB;
                end else begin
                    // Every remaining path retires here, keeping one PC update per instruction
                    w_pcw  = 1'b1;
                    w_done = 1'b1;
                    if (w_beq && zero) begin
                        w_pcs = 4'b0001;
                    end else if (w_jal) begin
                        w_rw    = 1'b1;
                        w_wdsel = 3'b010;
                        w_pcs   = 4'b0010;
                    end else if (w_jr) begin
                        w_pcs = 4'b0011;
                    end
                end
            end
            S_MEM: begin
                w_mr = w_lw;
                w_mw = w_sw;
                if (mem_ready && w_lw) begin
                    w_next = S_WB;
                end else if (mem_ready || w_timeout) begin
                    w_pcw  = 1'b1;
                    w_done = 1'b1;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_rw    = 1'b1;
                w_pcw   = 1'b1;
                w_done  = 1'b1;
                w_rdst  = (w_addu || w_subu) ? 3'b001 : 3'b000;
                w_wdsel = w_lw ? 3'b001 : 3'b000;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_MEM && w_next == S_MEM)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
            if (w_timeout)
                r_mem_timeout <= 1'b1;
        end
    end

    // Enables and pulses are forced low while reset is held, so an in-flight access drops at once
    assign state       = r_state;
    assign IRWrite     = w_irw  & ~reset;
    assign PCWrite     = w_pcw  & ~reset;
    assign RegWrite    = w_rw   & ~reset;
    assign MemRead     = w_mr   & ~reset;
    assign MemWrite    = w_mw   & ~reset;
    assign instr_done  = w_done & ~reset;
    assign illegal     = w_ill  & ~reset;
    assign PC_sel      = w_pcs;
    assign ALUcontrol  = w_aluc;
    assign ALUsrc      = w_alus;
    assign RegDst      = w_rdst;
    assign GRF_WD_sel  = w_wdsel;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vector table plus hand-written MEM corner sequences.
// Expected instruction latencies are queued at FETCH and popped when instr_done pulses.
// Inputs driven 1 time unit after posedge; outputs compared 2 units after posedge and at negedge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic [2:0] state;
    logic       IRWrite, PCWrite, ALUsrc, RegWrite, MemRead, MemWrite;
    logic       instr_done, illegal, mem_timeout;
    logic [3:0] PC_sel, ALUcontrol;
    logic [2:0] RegDst, GRF_WD_sel;

    multicycle_controller #(.WAIT_MAX(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .state(state), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PC_sel(PC_sel), .ALUcontrol(ALUcontrol), .ALUsrc(ALUsrc), .RegDst(RegDst),
        .GRF_WD_sel(GRF_WD_sel), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .instr_done(instr_done), .illegal(illegal),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] JAL = 6'b000011, ORI = 6'b001101, LUI = 6'b001111, BAD = 6'b111111;
    localparam logic [5:0] FADDU = 6'b100001, FSUBU = 6'b100011, FJR = 6'b001000, FADD = 6'b100000;

    typedef struct {
        int         lat;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   sb[$];
    int   errors = 0;
    int   checks = 0;
    int   lat = 0;

    function automatic vec_t v(input int l, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic rdy, input logic [2:0] st,
                               input logic irw, input logic pcw, input logic [3:0] pcs,
                               input logic [3:0] aluc, input logic alus, input logic [2:0] rdst,
                               input logic [2:0] wd, input logic rw, input logic mr,
                               input logic mw, input logic dn, input logic il);
        vec_t r;
        r.lat = l; r.op = o; r.fn = f; r.z = z; r.rdy = rdy;
        r.exp = {st, irw, pcw, pcs, aluc, alus, rdst, wd, rw, mr, mw, dn, il};
        return r;
    endfunction

    function automatic logic [24:0] act();
        return {state, IRWrite, PCWrite, PC_sel, ALUcontrol, ALUsrc, RegDst, GRF_WD_sel,
                RegWrite, MemRead, MemWrite, instr_done, illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, a, e);
        end
    endtask

    task automatic run_row(input vec_t r, input string nm);
        op = r.op; funct = r.fn; zero = r.z; mem_ready = r.rdy;
        if (r.lat != 0) sb.push_back(r.lat);
        #1;
        chk(nm, 32'(act()), 32'(r.exp));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: latency from FETCH to instr_done, one PC update per retirement
    initial forever begin
        @(negedge clk);
        if (reset) begin
            lat = 0;
        end else begin
            if (IRWrite) lat = 1;
            else lat++;
            chk("pcwrite_vs_done", 32'(PCWrite), 32'(instr_done));
            if (instr_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got instr_done=1, required none outstanding");
                end else begin
                    chk("latency", 32'(lat), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 200000");
        $fatal(1);
    end

    initial begin
        int i_addu, i_jr;
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        i_addu = tbl.size();
        tbl.push_back(v(4, R, FADDU, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FADDU, 0, 0, 1, 0, 0, 4'd0, 4'd1, 0, 3'd1, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FADDU, 0, 0, 2, 0, 0, 4'd0, 4'd1, 0, 3'd1, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FADDU, 0, 0, 4, 0, 1, 4'd0, 4'd1, 0, 3'd1, 3'd0, 1, 0, 0, 1, 0));
        // lw, three waits then ready
        tbl.push_back(v(8, LW, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, LW, 0, 0, 0, 1, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, LW, 0, 0, 0, 2, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(0, LW, 0, 0, 0, 3, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, LW, 0, 0, 1, 3, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, LW, 0, 0, 0, 4, 0, 1, 4'd0, 4'd4, 1, 3'd0, 3'd1, 1, 0, 0, 1, 0));
        // beq taken, then not taken
        tbl.push_back(v(3, BEQ, 0, 1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, BEQ, 0, 1, 0, 1, 0, 0, 4'd0, 4'd5, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, BEQ, 0, 1, 0, 2, 0, 1, 4'd1, 4'd5, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0));
        tbl.push_back(v(3, BEQ, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, BEQ, 0, 0, 0, 1, 0, 0, 4'd0, 4'd5, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, BEQ, 0, 0, 0, 2, 0, 1, 4'd0, 4'd5, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0));
        // jal, jr
        tbl.push_back(v(3, JAL, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, JAL, 0, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 3'd2, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, JAL, 0, 0, 0, 2, 0, 1, 4'd2, 4'd0, 0, 3'd2, 3'd2, 1, 0, 0, 1, 0));
        i_jr = tbl.size();
        tbl.push_back(v(3, R, FJR, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FJR, 0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FJR, 0, 0, 2, 0, 1, 4'd3, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 0));
        // ori with mem_ready held high outside MEM (must be ignored)
        tbl.push_back(v(4, ORI, 0, 0, 1, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, ORI, 0, 0, 1, 1, 0, 0, 4'd0, 4'd3, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, ORI, 0, 0, 1, 2, 0, 0, 4'd0, 4'd3, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, ORI, 0, 0, 1, 4, 0, 1, 4'd0, 4'd3, 1, 3'd0, 3'd0, 1, 0, 0, 1, 0));
        // subu, lui
        tbl.push_back(v(4, R, FSUBU, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FSUBU, 0, 0, 1, 0, 0, 4'd0, 4'd2, 0, 3'd1, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FSUBU, 0, 0, 2, 0, 0, 4'd0, 4'd2, 0, 3'd1, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FSUBU, 0, 0, 4, 0, 1, 4'd0, 4'd2, 0, 3'd1, 3'd0, 1, 0, 0, 1, 0));
        tbl.push_back(v(4, LUI, 0, 1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, LUI, 0, 1, 0, 1, 0, 0, 4'd0, 4'd6, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, LUI, 0, 1, 0, 2, 0, 0, 4'd0, 4'd6, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, LUI, 0, 1, 0, 4, 0, 1, 4'd0, 4'd6, 1, 3'd0, 3'd0, 1, 0, 0, 1, 0));
        // illegal opcode, illegal R-type funct
        tbl.push_back(v(2, BAD, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, BAD, 0, 0, 0, 1, 0, 1, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 1));
        tbl.push_back(v(2, R, FADD, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, R, FADD, 0, 0, 1, 0, 1, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 1, 1));
        // sw completing on the first MEM cycle
        tbl.push_back(v(4, SW, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, SW, 0, 0, 0, 1, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, SW, 0, 0, 0, 2, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, SW, 0, 0, 1, 3, 0, 1, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 1, 1, 0));

        // Reset state: FETCH, but every enable suppressed while reset is high
        #2;
        chk("reset_outputs", 32'(act()), 32'd0);
        chk("reset_timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) run_row(tbl[i], $sformatf("row%0d", i));

        // lw: ready arrives in the same cycle the wait counter reaches WAIT_MAX
        run_row(v(20, LW, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0), "lwmax_f");
        run_row(v(0, LW, 0, 0, 0, 1, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0), "lwmax_d");
        run_row(v(0, LW, 0, 0, 0, 2, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0), "lwmax_e");
        for (int k = 0; k < 15; k++)
            run_row(v(0, LW, 0, 0, 0, 3, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 1, 0, 0, 0),
                    $sformatf("lwmax_m%0d", k));
        run_row(v(0, LW, 0, 0, 1, 3, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 1, 0, 0, 0), "lwmax_ok");
        run_row(v(0, LW, 0, 0, 0, 4, 0, 1, 4'd0, 4'd4, 1, 3'd0, 3'd1, 1, 0, 0, 1, 0), "lwmax_wb");
        chk("lwmax_no_timeout", 32'(mem_timeout), 32'd0);

        // sw with mem_ready never arriving: 16 MEM cycles then abort
        run_row(v(19, SW, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0), "swto_f");
        run_row(v(0, SW, 0, 0, 0, 1, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0), "swto_d");
        run_row(v(0, SW, 0, 0, 0, 2, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0), "swto_e");
        for (int k = 0; k < 15; k++)
            run_row(v(0, SW, 0, 0, 0, 3, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 1, 0, 0),
                    $sformatf("swto_m%0d", k));
        chk("swto_before", 32'(mem_timeout), 32'd0);
        run_row(v(0, SW, 0, 0, 0, 3, 0, 1, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 1, 1, 0), "swto_abort");
        chk("swto_flag", 32'(mem_timeout), 32'd1);
        for (int i = 0; i < 4; i++) run_row(tbl[i_addu + i], $sformatf("after_to%0d", i));
        chk("swto_sticky", 32'(mem_timeout), 32'd1);

        // Reset asserted in the middle of a sw access
        run_row(v(0, SW, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 0), "swrst_f");
        run_row(v(0, SW, 0, 0, 0, 1, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0), "swrst_d");
        run_row(v(0, SW, 0, 0, 0, 2, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 0, 0, 0), "swrst_e");
        run_row(v(0, SW, 0, 0, 0, 3, 0, 0, 4'd0, 4'd4, 1, 3'd0, 3'd0, 0, 0, 1, 0, 0), "swrst_m0");
        #1;
        chk("swrst_mw_before", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("swrst_mw_async", 32'(MemWrite), 32'd0);
        chk("swrst_state_async", 32'(state), 32'd0);
        chk("swrst_all_low", 32'(act()), 32'd0);
        chk("swrst_timeout_clr", 32'(mem_timeout), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) run_row(tbl[i_jr + i], $sformatf("after_rst%0d", i));

        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
